fcp_credit_gate: RTL and testbench

- Injector-side credit checker between the FCP return path and the per-VC scheduler of the traffic injector; it sits directly upstream of the link into the switch.
- Holds per-VC FCCL, the latest credit limit reported by the switch, and per-VC FCTBS, total blocks sent.
- Answers scheduler "may VC v send N blocks?" queries with grant or deny. A grant is committed atomically.
- Pipelined at one query per cycle with read-after-write forwarding, so the injector never overruns switch buffers.

---
 rtl/fcp_pkg.sv | 29 ++
 rtl/fcp_credit_ram.sv | 27 ++
 rtl/fcp_credit_gate.sv | 167 ++++++++++++++++
 tb/tb_fcp_credit_gate.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fcp_pkg.sv
// Shared FCP definitions: counter widths, the modular credit compare, the FCP
// message payload used by the FCP generator, and the credit-gate FSM states.
package fcp_pkg;

   localparam int unsigned FCP_VC_WIDTH  = 10;
   localparam int unsigned FCP_LEN_WIDTH = 16;
   localparam int unsigned CREDIT_WIDTH  = 32;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } gate_state_e;

   typedef struct packed {
      logic [FCP_VC_WIDTH-1:0]  vc;
      logic [CREDIT_WIDTH-1:0]  fccl;
      logic [FCP_LEN_WIDTH-1:0] qlen;
      logic [CREDIT_WIDTH-1:0]  fccr;
   } fcp_msg_t;

   // True when the limit is not behind the proposed total (signed modular difference >= 0).
   function automatic logic credit_ok(input logic [CREDIT_WIDTH-1:0] fccl,
                                      input logic [CREDIT_WIDTH-1:0] fctbs_new);
      logic [CREDIT_WIDTH-1:0] diff;
      diff = fccl - fctbs_new;
      return ~diff[CREDIT_WIDTH-1];
   endfunction

endpackage

// File: rtl/fcp_credit_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old data.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
//        rd_data read result one cycle after rd_en, held otherwise.
module fcp_credit_ram #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fcp_credit_gate.sv
// Injector-side credit gate. Keeps per-VC FCCL (latest switch credit limit)
// and FCTBS (total blocks sent) and answers one scheduler query per cycle,
// committing the blocks on grant. Two-stage pipeline with forwarding.
// Ports: clk, rst (async, active high);
//        fcp_valid/fcp_vc/fcp_fccl   absolute credit-limit updates;
//        req_valid/req_ready/req_vc/req_blocks   scheduler queries;
//        resp_valid/resp_vc/resp_grant   response two cycles after accept;
//        init_done   table sweep complete;
//        stat_grant_count/stat_deny_count   saturating response counters.
module fcp_credit_gate
   import fcp_pkg::*;
#(
   parameter int unsigned QUEUE_INDEX_WIDTH = FCP_VC_WIDTH,
   parameter int unsigned LEN_WIDTH         = FCP_LEN_WIDTH,
   parameter int unsigned INIT_CREDIT       = 16,
   parameter int unsigned STAT_WIDTH        = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fcp_valid,
   input  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
   input  logic [CREDIT_WIDTH-1:0]      fcp_fccl,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [QUEUE_INDEX_WIDTH-1:0] req_vc,
   input  logic [LEN_WIDTH-1:0]         req_blocks,
   output logic                         resp_valid,
   output logic [QUEUE_INDEX_WIDTH-1:0] resp_vc,
   output logic                         resp_grant,
   output logic                         init_done,
   output logic [STAT_WIDTH-1:0]        stat_grant_count,
   output logic [STAT_WIDTH-1:0]        stat_deny_count
);

   gate_state_e                  state_q, state_d;
   logic [QUEUE_INDEX_WIDTH-1:0] sweep_q, sweep_d;
   logic                         in_init;

   logic                         acc, fcp_ok, fcp_hit_s0, fcp_hit_s1;

   logic                         fccl_we, tbs_we;
   logic [QUEUE_INDEX_WIDTH-1:0] fccl_wa, tbs_wa;
   logic [CREDIT_WIDTH-1:0]      fccl_wd, tbs_wd, fccl_rd, tbs_rd;

   logic                         s1_valid;
   logic [QUEUE_INDEX_WIDTH-1:0] s1_vc;
   logic [LEN_WIDTH-1:0]         s1_blocks;
   logic                         s1_fccl_fwd_v, s1_tbs_fwd_v;
   logic [CREDIT_WIDTH-1:0]      s1_fccl_fwd, s1_tbs_fwd;

   logic [CREDIT_WIDTH-1:0]      fccl_eff, tbs_eff, tbs_new, tbs_commit;
   logic                         grant_c;

   // Init sweep walks every VC once, then the gate runs forever.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         ST_INIT: begin
            sweep_d = sweep_q + QUEUE_INDEX_WIDTH'(1);
            if (sweep_q == '1) state_d = ST_RUN;
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_INIT;
         sweep_q   <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         req_ready <= (state_d == ST_RUN);
         init_done <= (state_d == ST_RUN);
      end
   end

   assign in_init    = (state_q == ST_INIT);
   assign acc        = req_valid & req_ready;
   assign fcp_ok     = fcp_valid & ~in_init;
   assign fcp_hit_s0 = fcp_ok & (fcp_vc == req_vc);
   assign fcp_hit_s1 = fcp_ok & (fcp_vc == s1_vc);

   // S1: newest FCCL wins (this-cycle FCP, then FCP seen at accept, then RAM).
   // FCTBS comes from the previous query when it hit the same VC one cycle earlier,
   // since the RAM read was issued in the same cycle as that query's write.
   always_comb begin
      fccl_eff = fccl_rd;
      if (fcp_hit_s1)         fccl_eff = fcp_fccl;
      else if (s1_fccl_fwd_v) fccl_eff = s1_fccl_fwd;
      tbs_eff    = s1_tbs_fwd_v ? s1_tbs_fwd : tbs_rd;
      tbs_new    = tbs_eff + CREDIT_WIDTH'(s1_blocks);
      grant_c    = credit_ok(fccl_eff, tbs_new);
      tbs_commit = grant_c ? tbs_new : tbs_eff;
   end

   // RAM write ports are owned by the sweep during init.
   always_comb begin
      fccl_we = in_init | fcp_ok;
      fccl_wa = in_init ? sweep_q : fcp_vc;
      fccl_wd = in_init ? CREDIT_WIDTH'(INIT_CREDIT) : fcp_fccl;
      tbs_we  = in_init | (s1_valid & grant_c);
      tbs_wa  = in_init ? sweep_q : s1_vc;
      tbs_wd  = in_init ? '0 : tbs_new;
   end

   fcp_credit_ram #(.ADDR_WIDTH(QUEUE_INDEX_WIDTH), .DATA_WIDTH(CREDIT_WIDTH)) u_fccl_ram (
      .clk     (clk),
      .wr_en   (fccl_we),
      .wr_addr (fccl_wa),
      .wr_data (fccl_wd),
      .rd_en   (acc),
      .rd_addr (req_vc),
      .rd_data (fccl_rd)
   );

   fcp_credit_ram #(.ADDR_WIDTH(QUEUE_INDEX_WIDTH), .DATA_WIDTH(CREDIT_WIDTH)) u_fctbs_ram (
      .clk     (clk),
      .wr_en   (tbs_we),
      .wr_addr (tbs_wa),
      .wr_data (tbs_wd),
      .rd_en   (acc),
      .rd_addr (req_vc),
      .rd_data (tbs_rd)
   );

   // Pipeline registers, response and statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid         <= 1'b0;
         s1_vc            <= '0;
         s1_blocks        <= '0;
         s1_fccl_fwd_v    <= 1'b0;
         s1_fccl_fwd      <= '0;
         s1_tbs_fwd_v     <= 1'b0;
         s1_tbs_fwd       <= '0;
         resp_valid       <= 1'b0;
         resp_vc          <= '0;
         resp_grant       <= 1'b0;
         stat_grant_count <= '0;
         stat_deny_count  <= '0;
      end else begin
         s1_valid      <= acc;
         s1_vc         <= req_vc;
         s1_blocks     <= req_blocks;
         s1_fccl_fwd_v <= acc & fcp_hit_s0;
         s1_fccl_fwd   <= fcp_fccl;
         s1_tbs_fwd_v  <= acc & s1_valid & (s1_vc == req_vc);
         s1_tbs_fwd    <= tbs_commit;
         resp_valid    <= s1_valid;
         resp_vc       <= s1_vc;
         resp_grant    <= s1_valid & grant_c;
         if (s1_valid) begin
            if (grant_c) begin
               if (stat_grant_count != '1) stat_grant_count <= stat_grant_count + STAT_WIDTH'(1);
            end else begin
               if (stat_deny_count != '1) stat_deny_count <= stat_deny_count + STAT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fcp_credit_gate.sv
// Directed bench for fcp_credit_gate: init sweep, grant/deny sequences,
// FCCL/FCTBS forwarding, modular compare and wrap, reset mid-flight.
module tb_fcp_credit_gate;

   logic        clk = 1'b0;
   logic        rst;
   logic        fcp_valid;
   logic [9:0]  fcp_vc;
   logic [31:0] fcp_fccl;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_vc;
   logic [15:0] req_blocks;
   logic        resp_valid;
   logic [9:0]  resp_vc;
   logic        resp_grant;
   logic        init_done;
   logic [31:0] stat_grant_count;
   logic [31:0] stat_deny_count;

   int vectors     = 0;
   int miscompares = 0;

   fcp_credit_gate dut (
      .clk              (clk),
      .rst              (rst),
      .fcp_valid        (fcp_valid),
      .fcp_vc           (fcp_vc),
      .fcp_fccl         (fcp_fccl),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_vc           (req_vc),
      .req_blocks       (req_blocks),
      .resp_valid       (resp_valid),
      .resp_vc          (resp_vc),
      .resp_grant       (resp_grant),
      .init_done        (init_done),
      .stat_grant_count (stat_grant_count),
      .stat_deny_count  (stat_deny_count)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_stats(input string tag, input logic [31:0] g, input logic [31:0] d);
      chk(tag, {stat_grant_count, stat_deny_count}, {g, d});
   endtask

   // Single isolated query; response checked two cycles after accept.
   task automatic query1(input logic [9:0] vc, input logic [15:0] blk, input logic g, input string tag);
      req_valid = 1'b1; req_vc = vc; req_blocks = blk;
      cyc();
      req_valid = 1'b0;
      cyc();
      chk(tag, 64'({resp_valid, resp_vc, resp_grant}), 64'({1'b1, vc, g}));
   endtask

   task automatic fcp1(input logic [9:0] vc, input logic [31:0] fccl);
      fcp_valid = 1'b1; fcp_vc = vc; fcp_fccl = fccl;
      cyc();
      fcp_valid = 1'b0;
   endtask

   // Counts 1024 clock edges after reset release; optionally fires FCPs during init.
   task automatic wait_init(input string tag, input logic with_fcp);
      int early;
      early = 0;
      for (int k = 1; k <= 1024; k++) begin
         cyc();
         fcp_valid = 1'b0;
         if (k < 1024 && (req_ready || init_done || resp_valid)) early++;
         if (k == 1023) chk({tag, "_ready_at_1023"}, 64'({req_ready, init_done}), 64'(0));
         if (with_fcp && (k == 10 || k == 1023)) begin
            fcp_valid = 1'b1;
            fcp_vc    = (k == 10) ? 10'd9 : 10'd10;
            fcp_fccl  = 32'd100;
         end
      end
      chk({tag, "_ready_at_1024"}, 64'({req_ready, init_done}), 64'(2'b11));
      chk({tag, "_early_outputs"}, 64'(early), 64'(0));
   endtask

   logic       exp2 [5];
   logic [9:0] tv   [20];
   logic       tg   [20];
   int         n7;
   int         leak;

   initial begin
      rst = 1'b1; fcp_valid = 1'b0; fcp_vc = '0; fcp_fccl = '0;
      req_valid = 1'b0; req_vc = '0; req_blocks = '0;
      exp2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset state and init sweep (FCPs inside init must be dropped).
      repeat (3) cyc();
      chk("reset_outputs", 64'({req_ready, init_done, resp_valid, resp_vc, resp_grant}), 64'(0));
      chk_stats("reset_stats", 32'd0, 32'd0);
      rst = 1'b0;
      wait_init("init1", 1'b1);

      // Five 4-block queries to VC5: 4 grants then deny.
      for (int i = 0; i < 6; i++) begin
         req_valid = (i < 5); req_vc = 10'd5; req_blocks = 16'd4;
         cyc();
         if (i == 0) chk("t2_no_resp_at_n1", 64'(resp_valid), 64'(0));
         else chk($sformatf("t2_q%0d", i - 1), 64'({resp_valid, resp_vc, resp_grant}),
                  64'({1'b1, 10'd5, exp2[i-1]}));
      end
      req_valid = 1'b0;
      chk_stats("t2_stats", 32'd4, 32'd1);

      // FCP in the accept cycle is visible; FCTBS ends at 20 (12 more fit exactly, then deny).
      fcp_valid = 1'b1; fcp_vc = 10'd5; fcp_fccl = 32'd32;
      query1(10'd5, 16'd4, 1'b1, "t3_same_cycle_fcp");
      fcp_valid = 1'b0;
      query1(10'd5, 16'd12, 1'b1, "t3_fctbs20_fill");
      query1(10'd5, 16'd1, 1'b0, "t3_fctbs20_full");

      // FCP in the S1 cycle of a VC6 query is visible.
      req_valid = 1'b1; req_vc = 10'd6; req_blocks = 16'd20;
      cyc();
      req_valid = 1'b0;
      fcp_valid = 1'b1; fcp_vc = 10'd6; fcp_fccl = 32'd20;
      cyc();
      fcp_valid = 1'b0;
      chk("t3_s1_fcp", 64'({resp_valid, resp_vc, resp_grant}), 64'({1'b1, 10'd6, 1'b1}));
      chk_stats("t3_stats", 32'd7, 32'd2);

      // VCs hit by FCP during init still hold 16.
      query1(10'd9, 16'd17, 1'b0, "t1_vc9_17_deny");
      query1(10'd10, 16'd17, 1'b0, "t1_vc10_17_deny");
      query1(10'd9, 16'd16, 1'b1, "t1_vc9_16_grant");

      // 17 one-block VC7 queries with three VC8 queries mixed in, one per cycle.
      n7 = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5 || i == 10 || i == 15) begin
            tv[i] = 10'd8; tg[i] = 1'b1;
         end else begin
            n7++;
            tv[i] = 10'd7; tg[i] = (n7 <= 16);
         end
      end
      for (int i = 0; i < 21; i++) begin
         req_valid = (i < 20); req_blocks = 16'd1;
         if (i < 20) req_vc = tv[i];
         cyc();
         if (i >= 1) chk($sformatf("t4_q%0d", i - 1), 64'({resp_valid, resp_vc, resp_grant}),
                         64'({1'b1, tv[i-1], tg[i-1]}));
      end
      req_valid = 1'b0;
      chk_stats("t4_stats", 32'd27, 32'd5);

      // Modular compare at the half-range boundary.
      fcp1(10'd3, 32'h7FFF_FFFF);
      query1(10'd3, 16'd1, 1'b1, "t5_7fffffff_grant");
      fcp1(10'd4, 32'h8000_0010);
      query1(10'd4, 16'd1, 1'b0, "t5_80000010_deny");

      // Preload VC11 FCTBS to 0xFFFFFFF0 with the limit tracking exactly.
      for (int i = 0; i < 65537; i++) begin
         req_valid = 1'b1; req_vc = 10'd11;
         fcp_valid = 1'b1; fcp_vc = 10'd11;
         if (i < 65536) begin
            req_blocks = 16'hFFFF;
            fcp_fccl   = 32'(i + 1) * 32'h0000_FFFF;
         end else begin
            req_blocks = 16'hFFF0;
            fcp_fccl   = 32'hFFFF_FFF0;
         end
         cyc();
      end
      req_valid = 1'b0; fcp_valid = 1'b0;
      cyc();
      cyc();
      chk_stats("t5_preload_stats", 32'd65565, 32'd6);
      fcp1(10'd11, 32'h0000_0008);
      query1(10'd11, 16'd20, 1'b1, "t5_wrap_grant");
      query1(10'd11, 16'd4, 1'b1, "t5_fctbs4_fill");
      query1(10'd11, 16'd1, 1'b0, "t5_fctbs4_full");
      chk_stats("t5_stats", 32'd65567, 32'd7);

      // Reset with two queries in flight.
      req_valid = 1'b1; req_vc = 10'd5; req_blocks = 16'd4;
      cyc();
      cyc();
      req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t6_reset_outputs", 64'({req_ready, init_done, resp_valid, resp_vc, resp_grant}), 64'(0));
      chk_stats("t6_reset_stats", 32'd0, 32'd0);
      leak = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (resp_valid) leak++;
      end
      chk("t6_no_resp_in_reset", 64'(leak), 64'(0));
      rst = 1'b0;
      wait_init("init2", 1'b0);
      query1(10'd5, 16'd16, 1'b1, "t6_vc5_16_grant");
      query1(10'd5, 16'd1, 1'b0, "t6_vc5_1_deny");
      chk_stats("t6_stats", 32'd1, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
